rtc_calendar_counter: RTL
=========================

// Module: rtc_calendar_counter
// PURPOSE
//  Real-time clock/calendar that produces the BCD-free binary counters and per-field display enables
//  consumed by control_decode_7seg (cnt_s..cnt_y_* / enable_s..enable_y). It counts sec/min/hour/day/
//  month/year from a prescaled 1 Hz tick, handles month lengths and leap years, and provides a
//  two-button set mode in which the field being edited blinks on the display.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per 1 s tick (benches use 4)
//  BLINK_DIV  12_500_000  clk cycles per blink phase toggle (benches use 2)
// PORTS
//  clk                     in   1  system clock, 50 MHz
//  rst_n                   in   1  asynchronous active-low reset
//  btn_mode                in   1  debounced level; rising edge advances edit field
//  btn_inc                 in   1  debounced level; rising edge increments edited field
//  cnt_s, cnt_mi           out  6  seconds / minutes 0..59
//  cnt_h                   out  6  hours 0..23
//  cnt_d                   out  6  day 1..days_in_month
//  cnt_mo                  out  6  month 1..12
//  cnt_y_thousand_hundred  out  7  year / 100, 0..99
//  cnt_y_ten_unit          out  7  year % 100, 0..99
//  enable_s,enable_mi,enable_h,enable_d,enable_mo,enable_y  out 1 each  display enable per field
// BEHAVIOUR
//  Reset (async, rst_n=0): 00:00:00, day 1, month 1, year 20|00; state RUN; all enables 1;
//   prescaler, blink counter, button history regs all 0. All outputs registered.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle when it wraps. Runs only in RUN.
//  RUN carry chain, all updated on the same edge as the tick:
//   s 59->0 carries mi; mi 59->0 carries h; h 23->0 carries d; d==dim->1 carries mo;
//   mo 12->1 carries year; ten_unit 99->0 carries thousand_hundred; year 99|99 -> 00|00.
//  dim (days in month): 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if leap else 28.
//   leap = (ten_unit%4==0) && (ten_unit!=0 || thousand_hundred%4==0).
//  Button edges: btn_x_q <= btn_x each clk; edge = btn_x & ~btn_x_q. Effect visible on outputs
//   at the clk edge following the edge cycle's sample (1-cycle latency).
//  FSM (btn_mode edge): RUN -> SET_Y -> SET_MO -> SET_D -> SET_H -> SET_MI -> RUN.
//   Entering SET_Y: prescaler cleared, time frozen. Leaving SET_MI->RUN: cnt_s<=0, prescaler<=0.
//  btn_inc edge in SET_*: edited field +1 with wrap, no carry into other fields:
//   SET_Y ten_unit 99->0 and thousand_hundred +1 (99|99->00|00); SET_MO 12->1; SET_D dim->1;
//   SET_H 23->0; SET_MI 59->0. btn_inc edge in RUN ignored.
//  Day clamp: whenever month or year changes (set or carry) and cnt_d > new dim, cnt_d <= new dim
//   on the same edge (e.g. 31 Mar -> set month to Apr gives 30; 29 Feb 2024 -> year 2025 gives 28).
//  Simultaneous btn_mode and btn_inc edges: mode transition only, inc discarded.
//  Blink: counter 0..BLINK_DIV-1 runs in SET_*, toggles phase on wrap; cleared with phase=1 on
//   every FSM transition. enable of edited field = phase; every other enable = 1. In RUN all = 1.
//   SET_Y drives enable_y for both year fields.
//  Mid-operation reset: returns to reset values immediately regardless of state.
// TESTING (TICK_DIV=4, BLINK_DIV=2)
//  1 Reset, run 60 ticks -> cnt_s 0..59 then 0, cnt_mi=1; enables all 1 throughout.
//  2 Preload via set mode 23:59:59 31 Dec 2099, one tick -> 00:00:00 1 Jan, year 21|00.
//  3 28 Feb 2100 23:59:59 + tick -> 1 Mar (2100 non-leap); 28 Feb 2000 -> 29 Feb (leap).
//  4 btn_mode x1 -> SET_Y, enable_y toggles every 2 cycles, cnt_s frozen; btn_inc x3 -> year 20|03;
//    btn_mode x5 -> RUN, cnt_s=0, enable_y=1.
//  5 Day 31 month 3, SET_MO + btn_inc -> month 4, day 30 on same edge; btn_mode and btn_inc
//    edges same cycle -> state advances, field unchanged.
//  6 Assert rst_n=0 while in SET_D mid-blink -> all outputs to reset values without waiting for clk.

Source files
------------

// File: rtl/rtc_calendar_counter.sv
// -----------------------------------------------------------------------------
// rtc_calendar_counter
//   Real-time clock/calendar. It counts seconds, minutes, hours, day, month and
//   year from a prescaled 1 s tick, with month lengths and leap years handled.
//   Two buttons drive a set mode. btn_mode steps through the editable fields and
//   btn_inc increments the field being edited. That field blinks through its
//   display enable.
//
// Ports
//   clk                     system clock
//   rst_n                   asynchronous active-low reset
//   btn_mode                debounced level; a rising edge advances the edit field
//   btn_inc                 debounced level; a rising edge increments the edited field
//   cnt_s, cnt_mi           seconds / minutes, 0..59
//   cnt_h                   hours, 0..23
//   cnt_d                   day of month, 1..days_in_month
//   cnt_mo                  month, 1..12
//   cnt_y_thousand_hundred  year / 100, 0..99
//   cnt_y_ten_unit          year % 100, 0..99
//   enable_*                per-field display enables (blink phase for the edited field)
// -----------------------------------------------------------------------------
module rtc_calendar_counter #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] cnt_s,
    output logic [5:0] cnt_mi,
    output logic [5:0] cnt_h,
    output logic [5:0] cnt_d,
    output logic [5:0] cnt_mo,
    output logic [6:0] cnt_y_thousand_hundred,
    output logic [6:0] cnt_y_ten_unit,
    output logic       enable_s,
    output logic       enable_mi,
    output logic       enable_h,
    output logic       enable_d,
    output logic       enable_mo,
    output logic       enable_y
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {RUN, SET_Y, SET_MO, SET_D, SET_H, SET_MI} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [BW-1:0] blink_reg, blink_next;
    logic          phase_reg, phase_next;
    logic          mode_q_reg, inc_q_reg;
    logic [5:0]    s_reg, s_next, mi_reg, mi_next, h_reg, h_next;
    logic [5:0]    d_reg, d_next, mo_reg, mo_next;
    logic [6:0]    th_reg, th_next, tu_reg, tu_next;
    logic [5:0]    enable_reg, enable_next;
    logic [5:0]    edit_sel;
    logic [5:0]    dim_cur, dim_new;
    logic [13:0]   year_inc_val;

    wire mode_edge = btn_mode & ~mode_q_reg;
    wire inc_edge  = btn_inc & ~inc_q_reg;

    // tu % 4 and th % 4 are simply the two low bits of the binary counts.
    function automatic logic [5:0] days_in_month(input logic [5:0] mo,
                                                 input logic [6:0] th,
                                                 input logic [6:0] tu);
        logic leap;
        leap = (tu[1:0] == 2'b00) && ((tu != 7'd0) || (th[1:0] == 2'b00));
        case (mo)
            6'd4, 6'd6, 6'd9, 6'd11: days_in_month = 6'd30;
            6'd2:                    days_in_month = leap ? 6'd29 : 6'd28;
            default:                 days_in_month = 6'd31;
        endcase
    endfunction

    assign dim_cur      = days_in_month(mo_reg, th_reg, tu_reg);
    assign year_inc_val = (tu_reg != 7'd99) ? {th_reg, tu_reg + 7'd1} :
                          (th_reg != 7'd99) ? {th_reg + 7'd1, 7'd0} : 14'd0;

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        blink_next = blink_reg;
        phase_next = phase_reg;
        s_next     = s_reg;
        mi_next    = mi_reg;
        h_next     = h_reg;
        d_next     = d_reg;
        mo_next    = mo_reg;
        th_next    = th_reg;
        tu_next    = tu_reg;
        dim_new    = 6'd31;

        if (state_reg == RUN) begin
            // A mode press wins over a coincident tick: time freezes on entry.
            if (mode_edge) begin
                state_next = SET_Y;
                presc_next = '0;
                blink_next = '0;
                phase_next = 1'b1;
            end else if (presc_reg == PRESC_MAX) begin
                presc_next = '0;
                if (s_reg != 6'd59) begin
                    s_next = s_reg + 6'd1;
                end else begin
                    s_next = '0;
                    if (mi_reg != 6'd59) begin
                        mi_next = mi_reg + 6'd1;
                    end else begin
                        mi_next = '0;
                        if (h_reg != 6'd23) begin
                            h_next = h_reg + 6'd1;
                        end else begin
                            h_next = '0;
                            if (d_reg != dim_cur) begin
                                d_next = d_reg + 6'd1;
                            end else begin
                                d_next = 6'd1;
                                if (mo_reg != 6'd12) begin
                                    mo_next = mo_reg + 6'd1;
                                end else begin
                                    mo_next = 6'd1;
                                    {th_next, tu_next} = year_inc_val;
                                end
                            end
                        end
                    end
                end
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end else if (mode_edge) begin
            // Mode press in set mode: advance field; any coincident inc is dropped.
            blink_next = '0;
            phase_next = 1'b1;
            case (state_reg)
                SET_Y:   state_next = SET_MO;
                SET_MO:  state_next = SET_D;
                SET_D:   state_next = SET_H;
                SET_H:   state_next = SET_MI;
                default: begin
                    state_next = RUN;
                    s_next     = '0;
                    presc_next = '0;
                end
            endcase
        end else begin
            if (blink_reg == BLINK_MAX) begin
                blink_next = '0;
                phase_next = ~phase_reg;
            end else begin
                blink_next = blink_reg + BW'(1);
            end
            if (inc_edge) begin
                case (state_reg)
                    SET_Y:   {th_next, tu_next} = year_inc_val;
                    SET_MO:  mo_next = (mo_reg == 6'd12) ? 6'd1 : mo_reg + 6'd1;
                    SET_D:   d_next  = (d_reg == dim_cur) ? 6'd1 : d_reg + 6'd1;
                    SET_H:   h_next  = (h_reg == 6'd23) ? 6'd0 : h_reg + 6'd1;
                    default: mi_next = (mi_reg == 6'd59) ? 6'd0 : mi_reg + 6'd1;
                endcase
            end
        end

        // A changed month/year may shorten the month below the current day.
        dim_new = days_in_month(mo_next, th_next, tu_next);
        if (d_next > dim_new) begin
            d_next = dim_new;
        end
    end

    // Bit order of edit_sel/enable: 0 s, 1 mi, 2 h, 3 d, 4 mo, 5 y.
    always_comb begin
        edit_sel = '0;
        case (state_next)
            SET_Y:   edit_sel[5] = 1'b1;
            SET_MO:  edit_sel[4] = 1'b1;
            SET_D:   edit_sel[3] = 1'b1;
            SET_H:   edit_sel[2] = 1'b1;
            SET_MI:  edit_sel[1] = 1'b1;
            default: edit_sel = '0;
        endcase
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_enable
        assign enable_next[gi] = edit_sel[gi] ? phase_next : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            presc_reg  <= '0;
            blink_reg  <= '0;
            phase_reg  <= 1'b1;
            mode_q_reg <= 1'b0;
            inc_q_reg  <= 1'b0;
            s_reg      <= '0;
            mi_reg     <= '0;
            h_reg      <= '0;
            d_reg      <= 6'd1;
            mo_reg     <= 6'd1;
            th_reg     <= 7'd20;
            tu_reg     <= 7'd0;
            enable_reg <= '1;
        end else begin
            state_reg  <= state_next;
            presc_reg  <= presc_next;
            blink_reg  <= blink_next;
            phase_reg  <= phase_next;
            mode_q_reg <= btn_mode;
            inc_q_reg  <= btn_inc;
            s_reg      <= s_next;
            mi_reg     <= mi_next;
            h_reg      <= h_next;
            d_reg      <= d_next;
            mo_reg     <= mo_next;
            th_reg     <= th_next;
            tu_reg     <= tu_next;
            enable_reg <= enable_next;
        end
    end

    assign cnt_s                  = s_reg;
    assign cnt_mi                 = mi_reg;
    assign cnt_h                  = h_reg;
    assign cnt_d                  = d_reg;
    assign cnt_mo                 = mo_reg;
    assign cnt_y_thousand_hundred = th_reg;
    assign cnt_y_ten_unit         = tu_reg;
    assign enable_s               = enable_reg[0];
    assign enable_mi              = enable_reg[1];
    assign enable_h               = enable_reg[2];
    assign enable_d               = enable_reg[3];
    assign enable_mo              = enable_reg[4];
    assign enable_y               = enable_reg[5];

endmodule
